// File: rtl/line_buffer_feeder.sv
// line_buffer_feeder: buffers three raster rows and feeds one 3-pixel column per shift request.
module line_buffer_feeder #(
   parameter int BIT_DEPTH  = 8,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BIT_DEPTH-1:0] pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic                 shift_buffer,
   output logic [BIT_DEPTH-1:0] out_l1,
   output logic [BIT_DEPTH-1:0] out_l2,
   output logic [BIT_DEPTH-1:0] out_l3,
   output logic                 out_valid,
   output logic                 line_valid,
   output logic                 row_end,
   output logic                 frame_done
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ALL_ROWS = RW'(IMG_HEIGHT);
   typedef enum logic [1:0] {FILL, READY, REFILL} state_t;
   state_t state, next_state;
   logic [BIT_DEPTH-1:0] mem [3][IMG_WIDTH];
   logic [1:0] wr_row, top;
   logic [CW-1:0] wr_col, rd_col;
   logic [RW-1:0] rows_loaded;
   logic accept, row_done, shift, sweep_done, last_sweep;
   function automatic logic [1:0] inc3(input logic [1:0] r);
      return (r == 2'd2) ? 2'd0 : r + 2'd1;
   endfunction
   assign pix_ready  = state != READY;
   assign line_valid = state == READY;
   assign accept     = pix_valid & pix_ready;
   assign row_done   = accept && wr_col == LAST_COL;
   assign shift      = shift_buffer && state == READY;
   assign sweep_done = shift && rd_col == LAST_COL;
   assign last_sweep = rows_loaded == ALL_ROWS;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= FILL;
      else state <= next_state;
   always_comb begin
      next_state = state;
      case (state)
         FILL:    if (row_done && rows_loaded == RW'(2)) next_state = READY;
         REFILL:  if (row_done) next_state = READY;
         READY:   if (sweep_done) next_state = last_sweep ? FILL : REFILL;
         default: next_state = FILL;
      endcase
   end
   // Row storage is deliberately left unreset; it is always rewritten before being read.
   always_ff @(posedge clk)
      if (accept) mem[wr_row][wr_col] <= pix_in;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_row      <= '0;
         wr_col      <= '0;
         rd_col      <= '0;
         top         <= '0;
         rows_loaded <= '0;
         out_l1      <= '0;
         out_l2      <= '0;
         out_l3      <= '0;
         out_valid   <= 1'b0;
         row_end     <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         row_end    <= 1'b0;
         frame_done <= 1'b0;
         if (accept) begin
            if (wr_col == LAST_COL) begin
               wr_col      <= '0;
               wr_row      <= inc3(wr_row);
               rows_loaded <= rows_loaded + RW'(1);
            end else wr_col <= wr_col + CW'(1);
         end
         if (shift) begin
            out_l1    <= mem[top][rd_col];
            out_l2    <= mem[inc3(top)][rd_col];
            out_l3    <= mem[inc3(inc3(top))][rd_col];
            out_valid <= 1'b1;
            if (rd_col == LAST_COL) begin
               rd_col  <= '0;
               row_end <= 1'b1;
               // The retired row slot is the old top, which is exactly where wr_row already points.
               if (last_sweep) begin
                  frame_done  <= 1'b1;
                  top         <= '0;
                  wr_row      <= '0;
                  wr_col      <= '0;
                  rows_loaded <= '0;
               end else top <= inc3(top);
            end else rd_col <= rd_col + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_line_buffer_feeder.sv
// tb_line_buffer_feeder: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_line_buffer_feeder;
   localparam int BD = 8, W = 4, H = 4;
   logic clk = 1'b0, rst = 1'b0;
   logic [BD-1:0] pix_in = '0;
   logic pix_valid = 1'b0, shift_buffer = 1'b0;
   logic pix_ready, out_valid, line_valid, row_end, frame_done;
   logic [BD-1:0] out_l1, out_l2, out_l3;
   int checks = 0, errors = 0;
   logic [3*BD+1:0] exp_q[$];

   line_buffer_feeder #(.BIT_DEPTH(BD), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .shift_buffer(shift_buffer), .out_l1(out_l1), .out_l2(out_l2), .out_l3(out_l3),
      .out_valid(out_valid), .line_valid(line_valid), .row_end(row_end), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Holds pix_valid high until the pixel is taken, with a bounded wait.
   task automatic send(input logic [BD-1:0] v);
      pix_in = v;
      pix_valid = 1'b1;
      for (int i = 0; i < 20 && !pix_ready; i++) tick;
      if (!pix_ready) chk("send_timeout", 32'(pix_ready), 32'd1);
      else tick;
   endtask

   task automatic fill(input bit gaps);
      for (int i = 0; i < 3 * W; i++) begin
         if (i == 3 * W - 1) chk("line_valid_before_last", 32'(line_valid), 32'd0);
         send(BD'((i / W) * 16 + (i % W)));
         if (gaps && (i % 3 == 1)) begin
            pix_valid = 1'b0;
            tick;
            tick;
         end
      end
      chk("fill_pix_ready", 32'(pix_ready), 32'd0);
      chk("fill_line_valid", 32'(line_valid), 32'd1);
      pix_valid = 1'b0;
   endtask

   task automatic send_row3(input bit gaps, input logic [3*BD-1:0] hold);
      for (int c = 0; c < W; c++) begin
         send(BD'(8'h30 + c));
         if (gaps) begin
            pix_valid = 1'b0;
            tick;
            if (c == 1) ignored_shift(hold);
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic sweep(input int base, input bit last);
      chk("sweep_line_valid", 32'(line_valid), 32'd1);
      for (int c = 0; c < W; c++) begin
         exp_q.push_back({BD'(base * 16 + c), BD'((base + 1) * 16 + c), BD'((base + 2) * 16 + c),
                          c == W - 1, last && c == W - 1});
         shift_buffer = 1'b1;
         tick;
         chk("shift_latency", 32'(out_valid), 32'd1);
      end
      shift_buffer = 1'b0;
      chk("post_sweep_line_valid", 32'(line_valid), 32'd0);
      chk("post_sweep_pix_ready", 32'(pix_ready), 32'd1);
   endtask

   task automatic ignored_shift(input logic [3*BD-1:0] hold);
      shift_buffer = 1'b1;
      tick;
      shift_buffer = 1'b0;
      chk("ignored_out_valid", 32'(out_valid), 32'd0);
      chk("ignored_hold", 32'({out_l1, out_l2, out_l3}), 32'(hold));
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_outs"}, 32'({out_l1, out_l2, out_l3}), 32'd0);
      chk({tag, "_flags"}, 32'({out_valid, line_valid, row_end, frame_done}), 32'd0);
      chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst && out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_column: got %h with nothing expected", {out_l1, out_l2, out_l3});
         end else begin
            logic [3*BD+1:0] e;
            e = exp_q.pop_front();
            if ({out_l1, out_l2, out_l3, row_end, frame_done} !== e) begin
               errors++;
               $display("FAIL column: got %h expected %h", {out_l1, out_l2, out_l3, row_end, frame_done}, e);
            end
         end
      end else if (rst && (row_end || frame_done)) begin
         checks++;
         errors++;
         $display("FAIL stray_pulse: got row_end=%0b frame_done=%0b expected 0", row_end, frame_done);
      end
   end

   initial begin
      repeat (3) tick;
      chk_cleared("reset_held");
      rst = 1'b1;
      tick;
      chk_cleared("reset_released");
      fill(1'b0);
      sweep(0, 1'b0);
      ignored_shift(24'h031323);
      send_row3(1'b1, 24'h031323);
      sweep(1, 1'b1);
      ignored_shift(24'h132333);
      fill(1'b1);
      sweep(0, 1'b0);
      send(8'h30);
      send(8'h31);
      pix_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk_cleared("reset_async");
      tick;
      rst = 1'b1;
      tick;
      fill(1'b0);
      sweep(0, 1'b0);
      send_row3(1'b0, 24'h031323);
      sweep(1, 1'b1);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/line_buffer_feeder.md
Name: line_buffer_feeder

Overview:
- Producer side of the 3-row window interface used by the convolution engine.
- Accepts a raster pixel stream on a valid/ready handshake and stores three image rows.
- On each shift_buffer request from the convolver, presents one column of the three buffered rows on out_l1/out_l2/out_l3, oldest row on out_l1.
- After a full row sweep, retires the oldest row and refills it from the stream. Repeats until the frame is exhausted.

Parameters:
BIT_DEPTH, 8, pixel width in bits
IMG_WIDTH, 8, pixels per image row (>=3)
IMG_HEIGHT, 8, rows per frame (>=3); number of row sweeps per frame = IMG_HEIGHT-2

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
pix_in  input  BIT_DEPTH  raster-order pixel data
pix_valid  input  1  pix_in valid
pix_ready  output  1  block can accept a pixel
shift_buffer  input  1  convolver request for next column, one column per high cycle
out_l1  output  BIT_DEPTH  column pixel from the oldest buffered row
out_l2  output  BIT_DEPTH  column pixel from the middle row
out_l3  output  BIT_DEPTH  column pixel from the newest row
out_valid  output  1  out_l* updated this cycle
line_valid  output  1  three rows resident; shift_buffer will be honoured
row_end  output  1  pulse with the last column of a sweep
frame_done  output  1  pulse with the last column of the last sweep

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Storage: 3 x IMG_WIDTH x BIT_DEPTH registers, used as a circular row store.
- Pointers:
  - wr_row and top each count 0..2, wrapping mod 3.
  - wr_col and rd_col each count 0..IMG_WIDTH-1.
  - rows_loaded counts 0..IMG_HEIGHT.
- States and transitions:
  - FILL: initial load.
  - READY: line_valid=1; go to REFILL after a sweep.
  - REFILL: replace the retired row.
- Reset (rst=0, immediate):
  - state=FILL; all pointers and counters 0.
  - out_l1/2/3=0; out_valid=0, line_valid=0, row_end=0, frame_done=0.
  - Row memory is not cleared; its contents are don't-care.
- pix_ready is combinational: 1 in FILL and REFILL, 0 in READY. It is therefore 1 while rst is low.
- Pixel accept (FILL/REFILL):
  - When pix_valid&pix_ready: mem[wr_row][wr_col]<=pix_in, then wr_col++.
  - At wr_col==IMG_WIDTH-1: wr_col<=0, wr_row<=wr_row+1 mod 3, rows_loaded++.
  - pix_valid low stalls with no state change.
- FILL->READY: when the third row completes. line_valid=1 from the next cycle.
- READY, shift_buffer=1:
  - Next cycle: out_l1<=mem[top][rd_col], out_l2<=mem[top+1 mod3][rd_col], out_l3<=mem[top+2 mod3][rd_col].
  - out_valid=1 for one cycle; rd_col++.
  - Latency: 1 cycle from shift sampled to data.
  - Back-to-back shifts give one column per cycle.
- Last column (rd_col==IMG_WIDTH-1 with shift):
  - row_end=1 alongside that data; rd_col<=0.
  - If rows_loaded==IMG_HEIGHT: frame_done=1 alongside the data. Go to FILL with all pointers and counters cleared, top=0, wr_row=0.
  - Otherwise: top<=top+1 mod 3 and go to REFILL. wr_row already equals the old top.
  - line_valid drops in the cycle following the last shift.
- REFILL->READY: when IMG_WIDTH pixels have been accepted into wr_row.
- shift_buffer while not READY is ignored: out_l* hold, out_valid=0.
- pix_valid in READY is not accepted (pix_ready=0); the upstream source holds the data.
- Outputs hold their last value between shifts.
- Arithmetic: all pointer wraps are explicit compares, never power-of-two truncation. No pixel arithmetic is performed.

Test Plan:
- Common setup: IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*16+col.
1. Hold rst low, then release -> out_l*=0, out_valid=0, line_valid=0, row_end=0, frame_done=0, pix_ready=1.
2. Stream 12 pixels with pix_valid constant -> pix_ready=0 and line_valid=1 starting the cycle after the 12th accept.
3. Assert shift_buffer for 4 cycles -> (l1,l2,l3) = (0x00,0x10,0x20), (0x01,0x11,0x21), (0x02,0x12,0x22), (0x03,0x13,0x23), each one cycle after its shift. row_end on the 4th. Then line_valid=0, pix_ready=1.
4. Stream row 3 (0x30..0x33), then 4 shifts -> (0x10,0x20,0x30) .. (0x13,0x23,0x33). row_end and frame_done on the last. State returns to FILL and line_valid=0.
5. Insert pix_valid gaps and pulse shift_buffer while line_valid=0 -> no extra writes, out_valid stays 0, outputs hold. Results of scenarios 3 and 4 are unchanged.
6. Drive rst low after 2 refill pixels -> outputs clear immediately. After release, a fresh 3-row fill reproduces the scenario 3 values.
